// File: rtl/pixel_unshuffle.sv
// pixel_unshuffle: splits a raster pixel stream into four banks by 2x2 phase
// (row parity, column parity), writing each pixel one cycle after acceptance.
module pixel_unshuffle #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = 8,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          unshuffle_en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [3:0]    bank_wen,
    output logic [AW-1:0] bank_addr,
    output logic [DW-1:0] bank_wdata,
    output logic          valid_un
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] base_q, base_d;
    logic [3:0]    wen_q, wen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          valid_q, valid_d;
    logic          accept, col_last, row_last;

    always_comb begin
        in_ready = (state_q == RUN) && unshuffle_en;
        accept   = in_valid && in_ready;
        col_last = col_q == CW'(IMG_W - 1);
        row_last = row_q == RW'(IMG_H - 1);
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        base_d   = base_q;
        if (state_q == IDLE) begin
            if (unshuffle_en) begin
                state_d = RUN;
                col_d   = '0;
                row_d   = '0;
                base_d  = '0;
            end
        end else if (state_q == RUN) begin
            if (!unshuffle_en) begin
                state_d = IDLE;
            end else if (accept) begin
                col_d = col_last ? '0 : col_q + 1'b1;
                if (col_last) begin
                    row_d = row_last ? '0 : row_q + 1'b1;
                    // base tracks (row>>1)*(IMG_W/2): bump it when leaving an odd row
                    base_d = row_q[0] ? base_q + AW'(IMG_W / 2) : base_q;
                    state_d = row_last ? DONE : RUN;
                end
            end
        end else if (!unshuffle_en) begin
            state_d = IDLE;
        end
        wen_d   = accept ? 4'b0001 << {row_q[0], col_q[0]} : 4'b0000;
        addr_d  = base_q + AW'(col_q >> 1);
        wdata_d = in_data;
        valid_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            wen_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
        end
    end

    assign bank_wen   = wen_q;
    assign bank_addr  = addr_q;
    assign bank_wdata = wdata_q;
    assign valid_un   = valid_q;
endmodule

// File: tb/tb_pixel_unshuffle.sv
// tb_pixel_unshuffle: directed + randomized checks of a 4x4 and a default 28x28 unshuffler
// against an arithmetic model of where each raster pixel must land.
module tb_pixel_unshuffle;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en_a, en_b, in_valid;
    logic [7:0] in_data;
    logic       rdy_a, rdy_b, vun_a, vun_b;
    logic [3:0] wen_a, wen_b;
    logic [7:0] addr_a, addr_b, wd_a, wd_b;

    pixel_unshuffle #(.IMG_W(4), .IMG_H(4), .DW(8), .AW(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .unshuffle_en(en_a), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_a), .bank_wen(wen_a), .bank_addr(addr_a), .bank_wdata(wd_a), .valid_un(vun_a)
    );

    pixel_unshuffle dut_b (
        .clk(clk), .rst_n(rst_n), .unshuffle_en(en_b), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_b), .bank_wen(wen_b), .bank_addr(addr_b), .bank_wdata(wd_b), .valid_un(vun_b)
    );

    typedef struct {int bank; int addr; int data; bit last;} wr_t;

    wr_t q_a[$], q_b[$];
    int  mem_a[4][64], mem_b[4][256];
    int  cnt_a[4], cnt_b[4];
    int  passed = 0, total = 0, fails = 0;
    bit  mon_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every observed write must match the oldest expected write of that instance.
    task automatic mon(input bit b, input logic [3:0] wen, input logic [7:0] addr,
                       input logic [7:0] wd, input logic vun);
        wr_t e;
        if (wen === 4'b0000) return;
        if (b ? q_b.size() == 0 : q_a.size() == 0) begin
            chk(b ? "unexpected_write_b" : "unexpected_write_a", 32'(wen), 0);
            return;
        end
        e = b ? q_b.pop_front() : q_a.pop_front();
        chk("write_strobe", 32'(wen), 32'(1 << e.bank));
        chk("write_addr", 32'(addr), e.addr);
        chk("write_data", 32'(wd), e.data);
        chk("valid_un_at_write", 32'(vun), 32'(e.last));
        if (b) begin
            mem_b[e.bank][e.addr] = e.data;
            cnt_b[e.bank]++;
        end else begin
            mem_a[e.bank][e.addr] = e.data;
            cnt_a[e.bank]++;
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon(1'b0, wen_a, addr_a, wd_a, vun_a);
            mon(1'b1, wen_b, addr_b, wd_b, vun_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        foreach (mem_a[i, j]) mem_a[i][j] = -1;
        foreach (cnt_a[i]) cnt_a[i] = 0;
    endtask

    // mode: 0 back-to-back, 1 bubble before every pixel after the first, 2 random bubbles
    // dmode: 0 data=k, 1 data=(row*28+col)%256, 2 random data
    task automatic job(input bit b, input int npix, input int mode, input int dmode);
        int w, r, c;
        logic [7:0] d;
        wr_t e;
        w = b ? 28 : 4;
        if (b) en_b = 1'b1; else en_a = 1'b1;
        step();
        for (int k = 0; k < npix; k++) begin
            r = k / w;
            c = k % w;
            if (mode == 1 && k > 0) begin
                in_valid = 1'b0;
                step();
            end
            if (mode == 2) begin
                while ($urandom_range(3) == 0) begin
                    in_valid = 1'b0;
                    step();
                end
            end
            d = dmode == 0 ? 8'(k) : dmode == 1 ? 8'((r * 28 + c) % 256) : 8'($urandom);
            in_valid = 1'b1;
            in_data  = d;
            chk("ready_in_run", 32'(b ? rdy_b : rdy_a), 1);
            e = '{(r % 2) * 2 + (c % 2), (r / 2) * (w / 2) + c / 2, int'(d), k == w * w - 1};
            if (b) q_b.push_back(e); else q_a.push_back(e);
            step();
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (npix == w * w) begin
            chk("valid_un_on_done", 32'(b ? vun_b : vun_a), 1);
            chk("ready_in_done", 32'(b ? rdy_b : rdy_a), 0);
        end
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);
    endtask

    task automatic check_seq_a();
        for (int k = 0; k < 16; k++)
            chk("bank_content", mem_a[(k / 4 % 2) * 2 + k % 2][(k / 8) * 2 + (k % 4) / 2], k);
        for (int i = 0; i < 4; i++) chk("writes_per_bank_a", cnt_a[i], 4);
    endtask

    initial begin
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; in_valid = 1'b0; in_data = '0;
        clear_a();
        foreach (cnt_b[i]) cnt_b[i] = 0;
        step();
        step();
        mon_on = 1'b1;
        chk("reset_wen", 32'(wen_a), 0);
        chk("reset_valid_un", 32'(vun_a), 0);
        chk("reset_addr", 32'(addr_a), 0);
        chk("reset_wdata", 32'(wd_a), 0);
        chk("reset_wen_b", 32'(wen_b), 0);
        en_a = 1'b1;
        in_valid = 1'b1;
        step();
        chk("ready_during_reset", 32'(rdy_a), 0);
        rst_n = 1'b1; en_a = 1'b0; in_valid = 1'b0;
        step();
        chk("ready_after_reset", 32'(rdy_a), 0);

        job(1'b0, 16, 0, 0);
        drain();
        check_seq_a();
        chk("b0_a2", mem_a[0][2], 8);
        chk("b1_a3", mem_a[1][3], 11);
        chk("b2_a1", mem_a[2][1], 6);
        chk("b3_a0", mem_a[3][0], 5);

        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("valid_un_hold", 32'(vun_a), 1);
            chk("ready_done_hold", 32'(rdy_a), 0);
        end
        en_a = 1'b0;
        step();
        chk("valid_un_drop", 32'(vun_a), 0);
        chk("ready_idle", 32'(rdy_a), 0);
        step();
        chk("ready_idle_valid", 32'(rdy_a), 0);
        in_valid = 1'b0;

        clear_a();
        job(1'b0, 16, 1, 0);
        drain();
        check_seq_a();
        en_a = 1'b0;
        step();

        for (int n = 0; n < 3; n++) begin
            job(1'b0, 16, 2, 2);
            drain();
            en_a = 1'b0;
            step();
            chk("valid_un_after_rand", 32'(vun_a), 0);
        end

        job(1'b0, 5, 0, 0);
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("valid_un_abort", 32'(vun_a), 0);
            chk("ready_abort", 32'(rdy_a), 0);
        end
        chk("abort_pending_written", q_a.size(), 0);
        clear_a();
        job(1'b0, 16, 0, 0);
        drain();
        check_seq_a();
        en_a = 1'b0;
        step();

        job(1'b0, 6, 0, 0);
        rst_n = 1'b0;
        in_valid = 1'b1;
        step();
        chk("midrun_reset_wen", 32'(wen_a), 0);
        chk("midrun_reset_valid_un", 32'(vun_a), 0);
        chk("midrun_reset_ready", 32'(rdy_a), 0);
        rst_n = 1'b1; en_a = 1'b0; in_valid = 1'b0;
        step();
        chk("midrun_pending_written", q_a.size(), 0);
        clear_a();
        job(1'b0, 16, 0, 0);
        drain();
        check_seq_a();
        en_a = 1'b0;
        step();

        job(1'b1, 784, 2, 1);
        drain();
        chk("last_pixel_28", mem_b[3][195], (27 * 28 + 27) % 256);
        for (int i = 0; i < 4; i++) chk("writes_per_bank_28", cnt_b[i], 196);
        chk("writes_total_28", cnt_b[0] + cnt_b[1] + cnt_b[2] + cnt_b[3], 784);
        en_b = 1'b0;
        step();
        chk("valid_un_drop_28", 32'(vun_b), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
